load_store_unit: RTL
====================

# load_store_unit

Initiator for the `ram` data port. It accepts RV32I load/store requests from the core through a valid/ready handshake and drives the RAM's `wEn`/`d_address`/`d_write_data` port. It performs byte and halfword extraction with sign or zero extension, implements SB/SH as a read-modify-write, flags misaligned or illegal accesses, and returns one response per request.

## Interface
- `DATA_WIDTH`, 32: RAM word width; the design supports only 32.
- `ADDR_WIDTH`, 16: byte address width, matching `ram`.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out 32: extended load data, or 0 for stores and errors.
- `resp_err` out 1: misaligned access or illegal funct3.
- `wEn` out 1: RAM write enable.
- `d_address` out ADDR_WIDTH: RAM word address, with the low 2 bits forced to 0.
- `d_write_data` out 32: RAM write data.
- `d_read_data` in 32: RAM read data, combinational from `d_address`.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we, funct3, addr and wdata.
  - A misaligned or illegal request goes to RESP with err=1. Any other request goes to ACCESS.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
- Illegal funct3: load funct3 3, 6 or 7; store funct3 greater than 2.
- ACCESS (`d_address` = latched address & ~3):
  - Load: capture the extended lane of `d_read_data`, then go to RESP.
  - SW: `wEn`=1 with `d_write_data`=wdata, then go to RESP.
  - SB/SH: capture the merged word (old word with the addressed lane replaced), then go to WRITE.
- WRITE: `wEn`=1 with `d_write_data` = merged word, then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `resp_rdata` and `resp_err` hold their values until the next RESP.
- Byte order is little-endian. Byte lane k is bits [8k+7:8k]. Halfword lane = addr[1] (lane 0 is bits 15:0).
- Extension: LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- An errored request never asserts `wEn`.
- `req_ready`=0 outside IDLE. `req_valid` in any other state is ignored; the unit never queues a request.

## Timing
- Request accepted at rising edge T (`req_valid`&`req_ready`). Response cycle:
  - Load and SW: resp in cycle T+2.
  - SB and SH: resp in cycle T+3.
  - Error: resp in cycle T+1.
- Back-to-back: the next request can be accepted at the edge that ends the RESP cycle plus one, because IDLE must be entered first.
- The RAM write occurs at the rising edge that ends the ACCESS cycle (SW) or the WRITE cycle (SB/SH).
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `wEn`=0, `d_address`=0, `d_write_data`=0.
- `wEn` is gated by `~reset`. If reset is asserted during ACCESS or WRITE, no RAM write occurs at that edge; the state returns to IDLE and the in-flight request is dropped with no response.
- `d_address` and `d_write_data` are registered from the latched request and are stable for the whole access.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (2 bits);
  - a `misaligned` function taking funct3 and addr[1:0].
- Sub-module `lsu_lane_align`: purely combinational. Inputs are the word, addr[1:0], funct3 and wdata. It outputs the extended load value and the merged store word. The FSM and registers stay in `load_store_unit`.

## Test plan
- SW to addr 8 with wdata 0xDEADBEEF:
  - `wEn` high for one cycle with `d_address`=8;
  - resp at T+2 with err=0;
  - a following LW from addr 8 returns 0xDEADBEEF.
- Loads from addr 9 with word 0xDEADBEEF at address 8:
  - LB returns 0xFFFFFFBE;
  - LBU returns 0x000000BE;
  - `d_address`=8 throughout.
- SB 0x11 to addr 10 over word 0xDEADBEEF at address 8:
  - `wEn` in WRITE only, with `d_write_data`=0xDE11BEEF;
  - resp at T+3.
  - SH 0x1234 to addr 8 afterwards gives 0xDE111234.
- Error cases, each giving resp_err=1 at T+1, `wEn` never asserted and `resp_rdata`=0:
  - LW from addr 6;
  - SH to addr 3;
  - load with funct3=3.
- Reset asserted during the WRITE cycle of an SB:
  - RAM word unchanged;
  - no `resp_valid`;
  - `req_ready`=1 the next cycle.
- Max address: LHU from 0xFFFE with word 0x8000ABCD at 0xFFFC:
  - returns 0x00008000;
  - `d_address`=0xFFFC.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access-legality helpers used at request acceptance.
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic illegal_funct3(input logic we, input logic [2:0] funct3);
    if (we) illegal_funct3 = (funct3 > F3_W);
    else    illegal_funct3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends the addressed load lane and
// builds the merged word for byte/halfword stores (little-endian lanes).
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for the RAM data port; one response per request,
// sub-word stores done as read-modify-write.
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] d_address,
  output logic [DATA_WIDTH-1:0] d_write_data,
  input  logic [DATA_WIDTH-1:0] d_read_data
);

  lsu_state_t            state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wen_q;
  logic                  req_bad;
  logic [31:0]           load_data;
  logic [31:0]           store_word;

  assign req_bad = misaligned(req_funct3, req_addr[1:0]) | illegal_funct3(req_we, req_funct3);

  // Reset must suppress a write already in flight at the edge it is sampled.
  assign wEn = wen_q & ~reset;

  lsu_lane_align u_align (
    .word       (d_read_data),
    .addr_lo    (addr_lo_q),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      wen_q        <= 1'b0;
      d_address    <= '0;
      d_write_data <= '0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            d_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            req_ready <= 1'b0;
            if (req_bad) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= S_ACCESS;
              if (req_we && req_funct3 == F3_W) begin
                wen_q        <= 1'b1;
                d_write_data <= req_wdata;
              end
            end
          end
        end
        S_ACCESS: begin
          wen_q <= 1'b0;
          if (we_q && funct3_q != F3_W) begin
            d_write_data <= store_word;
            wen_q        <= 1'b1;
            state        <= S_WRITE;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : load_data;
          end
        end
        S_WRITE: begin
          wen_q      <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
